// File: rtl/mem64_writeback_pkg.sv
// Shared constants and FSM encoding for the 8x8 tile write-back path.
// Element, data and tile geometry live here so the loader and writer agree.
package mem64_writeback_pkg;

  localparam int unsigned N     = 8;
  localparam int unsigned EW    = 22;
  localparam int unsigned DW    = 16;
  localparam int unsigned Words = N * N;
  localparam int unsigned CntW  = $clog2(Words);
  localparam int unsigned IdxW  = $clog2(N);

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StWrite = 2'd1,
    StDone  = 2'd2
  } wb_state_e;

endpackage

// File: rtl/counterr.sv
// Free-running up-counter with synchronous clear and count enable.
// Wraps modulo 2^size.
module counterr #(
  parameter int unsigned size = 6
) (
  input  logic            clock,
  input  logic            reset,
  input  logic            en,
  output logic [size-1:0] count
);

  always_ff @(posedge clock) begin
    if (reset) begin
      count <= '0;
    end else if (en) begin
      count <= count + size'(1);
    end
  end

endmodule

// File: rtl/sat_s22_s16.sv
// Combinational signed saturator from the element width down to the SRAM data width.
module sat_s22_s16
  import mem64_writeback_pkg::*;
(
  input  logic [EW-1:0] din,
  output logic [DW-1:0] dout
);

  logic [EW-DW:0] hi;
  logic           ovf;

  always_comb begin
    hi  = din[EW-1:DW-1];
    // Representable only when every bit above the target sign bit matches it.
    ovf = !((&hi) || !(|hi));
    if (!ovf) begin
      dout = din[DW-1:0];
    end else if (din[EW-1]) begin
      dout = {1'b1, {(DW-1){1'b0}}};
    end else begin
      dout = {1'b0, {(DW-1){1'b1}}};
    end
  end

endmodule

// File: rtl/mem64_writeback.sv
// Buffers an 8x8 tile of 22-bit results and streams it, saturated to 16 bits,
// to SRAM as 64 row-major words starting at a latched base address.
module mem64_writeback
  import mem64_writeback_pkg::*;
#(
  parameter int unsigned AW = 18
) (
  input  logic            clock,
  input  logic            reset,
  input  logic            row_wr,
  input  logic [2:0]      row_idx,
  input  logic [N*EW-1:0] row_in,
  input  logic            start,
  input  logic [AW-1:0]   base_addr,
  input  logic            w_ready,
  output logic            w_en,
  output logic [AW-1:0]   w_addr,
  output logic [DW-1:0]   w_data,
  output logic            busy,
  output logic            done
);

  localparam logic [CntW-1:0] LastWord = CntW'(Words - 1);

  wb_state_e       state_q, state_d;
  logic [AW-1:0]   base_q;
  logic [CntW-1:0] word_k;
  logic            start_ok;
  logic            row_ok;
  logic            cnt_en;
  logic            cnt_clr;
  logic [DW-1:0]   sat_word;

  logic [EW-1:0] tile_buf [Words];

  // Row writes and starts are only honoured while idle; same-cycle both lands the row first.
  assign start_ok = start && (state_q == StIdle);
  assign row_ok   = row_wr && (state_q == StIdle);
  assign cnt_en   = w_en && w_ready;
  assign cnt_clr  = reset || start_ok;

  always_ff @(posedge clock) begin
    if (row_ok) begin
      for (int j = 0; j < N; j++) begin
        tile_buf[{row_idx, IdxW'(j)}] <= row_in[N*EW-1-EW*j -: EW];
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= StIdle;
      base_q  <= '0;
    end else begin
      state_q <= state_d;
      if (start_ok) begin
        base_q <= base_addr;
      end
    end
  end

  counterr #(
    .size (CntW)
  ) u_cnt (
    .clock (clock),
    .reset (cnt_clr),
    .en    (cnt_en),
    .count (word_k)
  );

  sat_s22_s16 u_sat (
    .din  (tile_buf[word_k]),
    .dout (sat_word)
  );

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          state_d = StWrite;
        end
      end
      StWrite: begin
        if (w_ready && (word_k == LastWord)) begin
          state_d = StDone;
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // Outputs decode registered state only, so w_ready never reaches w_en combinationally.
  always_comb begin
    w_en   = 1'b0;
    busy   = 1'b0;
    done   = 1'b0;
    w_addr = '0;
    w_data = '0;
    if (state_q == StWrite) begin
      w_en   = 1'b1;
      busy   = 1'b1;
      w_addr = base_q + AW'(word_k);
      w_data = sat_word;
    end
    if (state_q == StDone) begin
      done = 1'b1;
    end
  end

endmodule

// File: tb/tb_mem64_writeback.sv
// Randomised self-checking bench for mem64_writeback against an integer tile model.
module tb_mem64_writeback;

  logic         clock;
  logic         reset;
  logic         row_wr;
  logic [2:0]   row_idx;
  logic [175:0] row_in;
  logic         start;
  logic [17:0]  base_addr;
  logic         w_ready;
  logic         w_en;
  logic [17:0]  w_addr;
  logic [15:0]  w_data;
  logic         busy;
  logic         done;

  int n_checks = 0;
  int n_fail   = 0;
  int model [64];

  mem64_writeback #(
    .AW (18)
  ) dut (
    .clock     (clock),
    .reset     (reset),
    .row_wr    (row_wr),
    .row_idx   (row_idx),
    .row_in    (row_in),
    .start     (start),
    .base_addr (base_addr),
    .w_ready   (w_ready),
    .w_en      (w_en),
    .w_addr    (w_addr),
    .w_data    (w_data),
    .busy      (busy),
    .done      (done)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  function automatic logic [15:0] sat_ref(input int x);
    if (x > 32767) return 16'h7FFF;
    else if (x < -32768) return 16'h8000;
    else return x[15:0];
  endfunction

  function automatic int rand_elem();
    if ($urandom_range(1, 0) == 1) return int'($urandom_range(65535, 0)) - 32768;
    else return int'($urandom_range(4194303, 0)) - 2097152;
  endfunction

  function automatic logic [175:0] pack_row(input int i);
    logic [175:0] r;
    logic [31:0]  v;
    r = '0;
    for (int j = 0; j < 8; j++) begin
      v = model[i*8+j];
      r[175-22*j -: 22] = v[21:0];
    end
    return r;
  endfunction

  task automatic load_tile();
    for (int i = 0; i < 8; i++) begin
      row_wr  = 1'b1;
      row_idx = 3'(i);
      row_in  = pack_row(i);
      tick();
    end
    row_wr = 1'b0;
  endtask

  // Starts a stream and checks every request against the model. Optional stall at word
  // stall_at, ignored start/row writes injected at word inject_at and in the done cycle,
  // and an optional row-0 write in the same cycle as start.
  task automatic run_stream(input string name, input logic [17:0] base, input int stall_at,
                            input int stall_len, input int inject_at, input bit row_with_start);
    int          k;
    int          cyc;
    int          stall_left;
    int          exp_done;
    bit          done_seen;
    bit          injected;
    logic [17:0] exp_addr;
    logic [15:0] exp_data;
    exp_done = 65 + stall_len;
    if (row_with_start) begin
      for (int j = 0; j < 8; j++) model[j] = rand_elem();
      row_wr  = 1'b1;
      row_idx = 3'd0;
      row_in  = pack_row(0);
    end
    start     = 1'b1;
    base_addr = base;
    w_ready   = 1'b1;
    tick();
    start      = 1'b0;
    row_wr     = 1'b0;
    k          = 0;
    cyc        = 1;
    stall_left = stall_len;
    done_seen  = 1'b0;
    injected   = 1'b0;
    while (!done_seen && cyc <= exp_done + 20) begin
      start  = 1'b0;
      row_wr = 1'b0;
      if (done) begin
        done_seen = 1'b1;
        n_checks++;
        if (k != 64 || cyc != exp_done) begin
          n_fail++;
          $display("FAIL %s_done_timing: words=%0d cycle=%0d, required words=64 cycle=%0d",
                   name, k, cyc, exp_done);
        end
        n_checks++;
        if (w_en !== 1'b0 || busy !== 1'b0) begin
          n_fail++;
          $display("FAIL %s_done_outputs: w_en=%b busy=%b, required 0 0", name, w_en, busy);
        end
        if (inject_at >= 0) begin
          start     = 1'b1;
          base_addr = ~base;
          row_wr    = 1'b1;
          row_idx   = 3'd0;
          for (int j = 0; j < 8; j++) row_in[175-22*j -: 22] = 22'($urandom);
        end
      end else begin
        if (k > 63) begin
          n_checks++;
          n_fail++;
          $display("FAIL %s_overrun: %0d words accepted, required 64 then done", name, k);
          break;
        end
        exp_addr = 18'((int'(base) + k) % 262144);
        exp_data = sat_ref(model[k]);
        n_checks++;
        if (w_en !== 1'b1 || busy !== 1'b1 || done !== 1'b0 ||
            w_addr !== exp_addr || w_data !== exp_data) begin
          n_fail++;
          $display("FAIL %s_word%0d: en=%b busy=%b done=%b addr=%h data=%h, required 1 1 0 %h %h",
                   name, k, w_en, busy, done, w_addr, w_data, exp_addr, exp_data);
        end
        if (k == inject_at && !injected) begin
          injected  = 1'b1;
          start     = 1'b1;
          base_addr = ~base;
          row_wr    = 1'b1;
          row_idx   = 3'd0;
          for (int j = 0; j < 8; j++) row_in[175-22*j -: 22] = 22'($urandom);
        end
        if (k == stall_at && stall_left > 0) begin
          w_ready = 1'b0;
          stall_left--;
        end else begin
          w_ready = 1'b1;
        end
        if (w_ready) k++;
      end
      tick();
      cyc++;
    end
    start   = 1'b0;
    row_wr  = 1'b0;
    w_ready = 1'b1;
    n_checks++;
    if (!done_seen) begin
      n_fail++;
      $display("FAIL %s_done_timeout: no done within %0d cycles, required at cycle %0d",
               name, exp_done + 20, exp_done);
    end else if (done !== 1'b0 || busy !== 1'b0 || w_en !== 1'b0) begin
      n_fail++;
      $display("FAIL %s_after_done: done=%b busy=%b w_en=%b, required 0 0 0",
               name, done, busy, w_en);
    end
  endtask

  task automatic test_reset();
    reset   = 1'b1;
    tick();
    tick();
    n_checks++;
    if (w_en !== 1'b0 || w_addr !== 18'h0 || w_data !== 16'h0 || busy !== 1'b0 ||
        done !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_state: en=%b addr=%h data=%h busy=%b done=%b, required all zero",
               w_en, w_addr, w_data, busy, done);
    end
    reset = 1'b0;
    tick();
  endtask

  task automatic test_ramp();
    for (int k = 0; k < 64; k++) model[k] = k;
    load_tile();
    run_stream("ramp", 18'h00100, -1, 0, -1, 1'b0);
  endtask

  task automatic test_saturation();
    for (int k = 0; k < 64; k++) model[k] = rand_elem();
    model[0] = -1;
    model[1] = 32768;
    model[2] = -32769;
    model[3] = 32767;
    model[4] = 2097151;
    model[5] = -2097152;
    load_tile();
    run_stream("sat", 18'(($urandom)), -1, 0, -1, 1'b0);
  endtask

  task automatic test_stall();
    for (int k = 0; k < 64; k++) model[k] = rand_elem();
    load_tile();
    run_stream("stall", 18'h01000, 10, 3, -1, 1'b0);
  endtask

  task automatic test_wrap();
    run_stream("wrap", 18'h3FFF0, -1, 0, -1, 1'b0);
  endtask

  task automatic test_reset_mid();
    start     = 1'b1;
    base_addr = 18'h02000;
    w_ready   = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < 20; i++) tick();
    n_checks++;
    if (w_en !== 1'b1 || w_addr !== 18'h02014) begin
      n_fail++;
      $display("FAIL rstmid_k20: w_en=%b addr=%h, required 1 02014", w_en, w_addr);
    end
    reset = 1'b1;
    tick();
    n_checks++;
    if (w_en !== 1'b0 || busy !== 1'b0 || done !== 1'b0) begin
      n_fail++;
      $display("FAIL rstmid_drop: w_en=%b busy=%b done=%b, required 0 0 0", w_en, busy, done);
    end
    reset = 1'b0;
    tick();
    run_stream("rstmid_restart", 18'h02000, -1, 0, -1, 1'b0);
  endtask

  task automatic test_ignored();
    for (int k = 0; k < 64; k++) model[k] = rand_elem();
    load_tile();
    run_stream("ignored", 18'h0ABC0, -1, 0, 5, 1'b0);
    run_stream("ignored_recheck", 18'h00040, -1, 0, -1, 1'b0);
  endtask

  task automatic test_same_cycle_row();
    run_stream("same_cycle", 18'h00200, 2, 1, -1, 1'b1);
  endtask

  initial begin
    reset     = 1'b1;
    row_wr    = 1'b0;
    row_idx   = 3'd0;
    row_in    = '0;
    start     = 1'b0;
    base_addr = '0;
    w_ready   = 1'b1;
    test_reset();
    test_ramp();
    test_saturation();
    test_stall();
    test_wrap();
    test_reset_mid();
    test_ignored();
    test_same_cycle_row();
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
